// File: rtl/fuel_pkg.sv
// Shared definitions for the fuel dispenser: the fuel quantity width used by
// both the fuel-needed calculator and the dispenser controller, and the
// controller state encoding.
package fuel_pkg;

    localparam int FUEL_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUMP = 2'd1,
        DONE = 2'd2
    } fuel_state_t;

endpackage

// File: rtl/unit_timer.sv
// Per-unit cycle timer: counts 0..UNIT_CYCLES-1 while enabled and wraps.
// o_tc flags the last cycle of a unit from the registered count.
module unit_timer #(
    parameter int unsigned UNIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_tc
);

    localparam int CNT_W = $clog2(UNIT_CYCLES);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(UNIT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_tc;

    assign w_tc = (r_count == TC_VAL);
    assign o_tc = w_tc;

    // Counter: clear has priority over counting so a fresh transaction or an
    // abort never inherits a partial unit.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= w_tc ? '0 : r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fuel_dispenser_ctrl.sv
// Fuel dispenser controller. Accepts a unit count, runs the pump for
// UNIT_CYCLES clocks per unit, and reports completed units. Releasing the
// nozzle (stop) aborts; a unit finishing on the same edge is still counted.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready for a request; dispensed/aborted hold last result
//   PUMP  | pump running, timer counting cycles of the current unit
//   DONE  | single-cycle completion pulse, then back to IDLE
module fuel_dispenser_ctrl
    import fuel_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [FUEL_W-1:0] fuel_needed,
    input  logic              stop,
    output logic              pump_on,
    output logic              unit_pulse,
    output logic [FUEL_W-1:0] dispensed,
    output logic              done,
    output logic              aborted
);

    fuel_state_t       r_state;
    fuel_state_t       w_state_nxt;
    logic [FUEL_W-1:0] r_target;
    logic [FUEL_W-1:0] r_dispensed;
    logic              r_aborted;

    logic              w_accept;
    logic              w_in_pump;
    logic              w_tc;
    logic              w_unit_done;
    logic              w_last_unit;
    logic              w_timer_clr;
    logic [FUEL_W-1:0] w_disp_inc;

    assign w_accept    = (r_state == IDLE) && req_valid;
    assign w_in_pump   = (r_state == PUMP);
    assign w_unit_done = w_in_pump && w_tc;
    assign w_disp_inc  = r_dispensed + FUEL_W'(1);
    // dispensed < target while pumping, so the increment cannot wrap.
    assign w_last_unit = w_unit_done && (w_disp_inc == r_target);
    assign w_timer_clr = w_accept || (w_in_pump && (stop || w_last_unit));

    unit_timer #(
        .UNIT_CYCLES (UNIT_CYCLES)
    ) u_unit_timer (
        .clk      (clk),
        .rst      (rst),
        .i_enable (w_in_pump),
        .i_clear  (w_timer_clr),
        .o_tc     (w_tc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and Moore output decode from registered state/counter.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        pump_on     = 1'b0;
        unit_pulse  = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = (fuel_needed == '0) ? DONE : PUMP;
                end
            end
            PUMP: begin
                pump_on    = 1'b1;
                unit_pulse = w_tc;
                if (w_last_unit || stop) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Transaction datapath: target latch, unit count and abort flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_target    <= '0;
            r_dispensed <= '0;
            r_aborted   <= 1'b0;
        end else if (w_accept) begin
            r_target    <= fuel_needed;
            r_dispensed <= '0;
            r_aborted   <= 1'b0;
        end else if (w_in_pump) begin
            if (w_unit_done) begin
                r_dispensed <= w_disp_inc;
            end
            // A final unit completing with stop is a normal completion.
            if (stop && !w_last_unit) begin
                r_aborted <= 1'b1;
            end
        end
    end

    assign dispensed = r_dispensed;
    assign aborted   = r_aborted;

endmodule

// File: tb/tb_fuel_dispenser_ctrl.sv
// Scoreboard bench for fuel_dispenser_ctrl (UNIT_CYCLES=4). The driver pushes
// the hand-computed outcome of each transaction when it is accepted; the
// monitor pops and compares whenever done pulses.
module tb_fuel_dispenser_ctrl;

    localparam int UC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] fuel_needed;
    logic       stop;
    logic       pump_on;
    logic       unit_pulse;
    logic [7:0] dispensed;
    logic       done;
    logic       aborted;

    typedef struct {
        int disp;
        int abrt;
        int lat;     // cycle of done, counting the first PUMP cycle as 1
        int pulses;
        int pumps;
        int acc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;

    fuel_dispenser_ctrl #(.UNIT_CYCLES(UC)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .fuel_needed (fuel_needed),
        .stop        (stop),
        .pump_on     (pump_on),
        .unit_pulse  (unit_pulse),
        .dispensed   (dispensed),
        .done        (done),
        .aborted     (aborted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Monitor: pulse/pump counting per transaction, done-time comparison.
    int  mon_pulses = 0;
    int  mon_pumps  = 0;
    bit  prev_done  = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            mon_pulses = 0;
            mon_pumps  = 0;
            prev_done  = 1'b0;
        end else begin
            if (prev_done) begin
                chk("ready_after_done", int'(req_ready), 1);
                chk("done_one_cycle", int'(done), 0);
            end
            prev_done = done;
            if (unit_pulse) mon_pulses++;
            if (pump_on) mon_pumps++;
            if (done) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_done: got done with empty scoreboard (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("done_pump_off", int'(pump_on), 0);
                    chk("dispensed", int'(dispensed), e.disp);
                    chk("aborted", int'(aborted), e.abrt);
                    chk("done_cycle", cyc - e.acc + 1, e.lat);
                    chk("unit_pulses", mon_pulses, e.pulses);
                    chk("pump_cycles", mon_pumps, e.pumps);
                end
                mon_pulses = 0;
                mon_pumps  = 0;
            end
        end
    end

    // Drive a request from a negedge; returns #1 into the first post-accept cycle.
    task automatic accept(input int f, input bit hold);
        @(negedge clk);
        chk("ready_in_idle", int'(req_ready), 1);
        req_valid   = 1'b1;
        fuel_needed = 8'(f);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic push(input int d, input int a, input int l, input int p, input int pu);
        exp_t e;
        e.disp = d; e.abrt = a; e.lat = l; e.pulses = p; e.pumps = pu; e.acc = acc_cyc;
        sb_q.push_back(e);
    endtask

    // From cycle 1, assert stop so it is sampled at the end of cycle n.
    task automatic stop_in(input int n);
        repeat (n - 1) @(posedge clk);
        #1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while (sb_q.size() != 0 && i < budget) begin
            @(posedge clk);
            i++;
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        fuel_needed = 8'd0;
        stop        = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pump_on", int'(pump_on), 0);
        chk("rst_unit_pulse", int'(unit_pulse), 0);
        chk("rst_done", int'(done), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_dispensed", int'(dispensed), 0);
        chk("rst_aborted", int'(aborted), 0);

        // Normal 3-unit transaction.
        accept(3, 1'b0);
        push(3, 0, 13, 3, 12);
        wait_drain(100);

        // Zero request goes straight to DONE.
        accept(0, 1'b0);
        push(0, 0, 1, 0, 0);
        wait_drain(100);

        // Abort mid-unit: partial unit not counted.
        accept(5, 1'b0);
        push(1, 1, 7, 1, 6);
        stop_in(6);
        wait_drain(100);
        repeat (3) @(negedge clk);
        chk("hold_dispensed", int'(dispensed), 1);
        chk("hold_aborted", int'(aborted), 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("idle_stop_ready", int'(req_ready), 1);
        chk("idle_stop_pump", int'(pump_on), 0);
        chk("idle_stop_dispensed", int'(dispensed), 1);

        // Stop on the final unit's terminal count completes normally.
        accept(2, 1'b0);
        push(2, 0, 9, 2, 8);
        stop_in(8);
        wait_drain(100);

        // Stop on a non-final terminal count: unit counted, still aborted.
        accept(3, 1'b0);
        push(2, 1, 9, 2, 8);
        stop_in(8);
        wait_drain(100);

        // Requests ignored while pumping, then reset mid-PUMP.
        accept(3, 1'b1);
        fuel_needed = 8'd7;
        @(posedge clk); #1;
        chk("busy_ready", int'(req_ready), 0);
        chk("busy_pump_on", int'(pump_on), 1);
        repeat (3) @(posedge clk); #1;
        chk("busy_dispensed", int'(dispensed), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_pump_on", int'(pump_on), 0);
        chk("midrst_dispensed", int'(dispensed), 0);
        chk("midrst_ready", int'(req_ready), 1);
        chk("midrst_done", int'(done), 0);
        rst       = 1'b0;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("postrst_idle_ready", int'(req_ready), 1);

        // Single unit after reset.
        accept(1, 1'b0);
        push(1, 0, 5, 1, 4);
        wait_drain(100);

        // Full-scale request: no wrap of dispensed.
        accept(255, 1'b0);
        push(255, 0, 1021, 255, 1020);
        wait_drain(1200);
        repeat (2) @(negedge clk);
        chk("full_hold_dispensed", int'(dispensed), 255);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fuel_dispenser_ctrl.md
FUEL_DISPENSER_CTRL -- requirements
Module: fuel_dispenser_ctrl

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 4: clock cycles per dispensed fuel unit (legal range 2..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1 bit: fuel_needed is valid.
REQ-005 SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-006 SHALL have port fuel_needed, input, 8 bits: unsigned units to dispense, from the fuel-needed calculator.
REQ-007 SHALL have port stop, input, 1 bit: nozzle released; abort dispensing.
REQ-008 SHALL have port pump_on, output, 1 bit: pump motor enable.
REQ-009 SHALL have port unit_pulse, output, 1 bit: one-cycle pulse per completed unit.
REQ-010 SHALL have port dispensed, output, 8 bits: units completed in the current or last transaction.
REQ-011 SHALL have port done, output, 1 bit: one-cycle transaction-complete pulse.
REQ-012 SHALL have port aborted, output, 1 bit: qualifies done; the transaction ended by stop.

Function
REQ-013 SHALL implement an FSM with states IDLE, PUMP and DONE; all outputs SHALL decode from registered state only (Moore).
REQ-014 SHALL drive req_ready=1 only in IDLE; a request SHALL be accepted on an edge where req_valid and req_ready are both 1.
REQ-015 On acceptance, SHALL latch target=fuel_needed, clear dispensed to 0, clear the cycle counter, and move to PUMP (target>0) or DONE (target==0).
REQ-016 In PUMP, SHALL drive pump_on=1, and the cycle counter SHALL count 0..UNIT_CYCLES-1 and wrap.
REQ-017 SHALL assert unit_pulse in the PUMP cycle where the counter equals UNIT_CYCLES-1; dispensed SHALL increment by 1 on that edge.
REQ-018 When the increment makes dispensed equal target, SHALL move to DONE with aborted=0; PUMP therefore lasts exactly target*UNIT_CYCLES cycles.
REQ-019 On stop=1 in PUMP, SHALL move to DONE with aborted=1, drop pump_on the next cycle, and not count the partial unit.
REQ-020 If stop coincides with a terminal count, SHALL count the unit; if it is the final unit, aborted=0, otherwise aborted=1.
REQ-021 DONE SHALL last exactly one cycle with done=1 and pump_on=0, then return to IDLE.
REQ-022 dispensed and aborted SHALL hold their values in IDLE until the next accepted request.
REQ-023 SHALL ignore stop in IDLE and DONE, and ignore req_valid outside IDLE.
REQ-024 dispensed SHALL never exceed target and SHALL never wrap; target=255 SHALL complete with dispensed=255.

Reset
REQ-025 On rst=1 at a rising edge, from any state including mid-PUMP, SHALL enter IDLE with the counter=0, dispensed=0, target=0 and aborted=0.
REQ-026 During and after reset, SHALL drive pump_on=0, unit_pulse=0 and done=0, with req_ready=1 from the first cycle after reset.
REQ-027 rst SHALL take priority over req_valid and stop.

Structure
REQ-028 Package fuel_pkg SHALL hold localparam FUEL_W=8 and the state enum typedef (IDLE, PUMP, DONE); the calculator and this block SHALL share FUEL_W.
REQ-029 The cycle counter SHALL be a sub-module, unit_timer (enable, clear, terminal-count output), parameterised by UNIT_CYCLES.

Verification (UNIT_CYCLES=4; cycle 0 = acceptance edge)
REQ-030 fuel_needed=3 accepted -> unit_pulse in cycles 4, 8, 12; pump_on high for cycles 1-12; done=1, aborted=0 and dispensed=3 in cycle 13; req_ready=1 in cycle 14.
REQ-031 fuel_needed=0 -> DONE the next cycle, pump_on never high, no unit_pulse, dispensed=0.
REQ-032 fuel_needed=5, stop=1 in cycle 6 -> dispensed=1, done=1 with aborted=1 in cycle 7, pump_on=0 from cycle 7.
REQ-033 fuel_needed=2, stop=1 coincident with the second unit_pulse -> dispensed=2, aborted=0; repeated with fuel_needed=3 -> dispensed=2, aborted=1.
REQ-034 req_valid held high with new values during PUMP -> req_ready=0 and the new values are ignored; rst in cycle 5 -> IDLE, pump_on=0 and dispensed=0 next cycle.
REQ-035 fuel_needed=255 -> 255 unit_pulses, done in cycle 1021, dispensed=255 with no wrap.
